// File: rtl/sine_phase_gen.sv
// sine_phase_gen: phase-accumulator front end for a quarter-wave sine ROM.
// It folds the phase into a first-quadrant ROM address and records a sign
// flag. It then turns the ROM's registered magnitude into a signed
// full-wave sample stream.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start               one-cycle pulse, accepted only in IDLE
//   stop                level, ends issuing while in RUN
//   tuning_word         phase increment, latched on accepted start
//   burst_len           samples per run, latched on accepted start (0 = continuous)
//   rom_addr            registered quarter-wave ROM address
//   rom_data            ROM magnitude, valid one cycle after rom_addr
//   sample              signed sample (DATA_W+1 bits), registered
//   sample_valid        sample strobe
//   busy                run or drain in progress
//   done                one-cycle pulse when the pipeline has emptied
module sine_phase_gen #(
  parameter int PHASE_W = 16,
  parameter int ADDR_W  = 4,
  parameter int DATA_W  = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic [PHASE_W-1:0] tuning_word,
  input  logic [15:0]        burst_len,
  output logic [ADDR_W-1:0]  rom_addr,
  input  logic [DATA_W-1:0]  rom_data,
  output logic [DATA_W:0]    sample,
  output logic               sample_valid,
  output logic               busy,
  output logic               done
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t             state, state_nx;
  logic [PHASE_W-1:0] phase, tw;
  logic [15:0]        cnt, blen, cnt_inc;
  logic               drain_last;   // set when the next DRAIN cycle is the final one
  logic               issue;
  logic [2:0]         vld_pipe;     // [0] with rom_addr, [1] with rom_data, [2] with sample
  logic [1:0]         neg_pipe;     // sign flag travelling alongside vld_pipe[1:0]

  logic [1:0]         quad;
  logic [ADDR_W-1:0]  idx, fold_addr;
  logic [DATA_W:0]    mag;

  assign cnt_inc   = cnt + 16'd1;
  assign quad      = phase[PHASE_W-1 -: 2];
  // Low phase bits below idx are simply dropped (truncation, no rounding).
  assign idx       = phase[PHASE_W-3 -: ADDR_W];
  // Odd quadrants run the quarter wave backwards.
  assign fold_addr = quad[0] ? ~idx : idx;
  assign mag       = {1'b0, rom_data};

  assign sample_valid = vld_pipe[2];

  always_comb begin
    state_nx = state;
    issue    = 1'b0;
    case (state)
      IDLE:  if (start) state_nx = RUN;
      RUN: begin
        if (stop) begin
          state_nx = DRAIN;
        end else begin
          issue = 1'b1;
          if (blen != 16'd0 && cnt_inc == blen) state_nx = DRAIN;
        end
      end
      DRAIN: if (drain_last) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      phase      <= '0;
      tw         <= '0;
      cnt        <= '0;
      blen       <= '0;
      drain_last <= 1'b0;
      vld_pipe   <= '0;
      neg_pipe   <= '0;
      rom_addr   <= '0;
      sample     <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state <= state_nx;
      busy  <= (state != IDLE);
      done  <= (state == DRAIN) && drain_last;

      if (state == IDLE && start) begin
        tw    <= tuning_word;
        blen  <= burst_len;
        phase <= '0;
        cnt   <= '0;
      end

      // A stop cycle issues nothing, so it already counts as the first
      // drain cycle; a burst-end exit needs the full two drain cycles.
      if (state == RUN)        drain_last <= stop;
      else if (state == DRAIN) drain_last <= 1'b1;

      if (issue) begin
        rom_addr    <= fold_addr;
        phase       <= phase + tw;
        cnt         <= cnt_inc;
        neg_pipe[0] <= quad[1];
      end
      neg_pipe[1] <= neg_pipe[0];
      vld_pipe    <= {vld_pipe[1:0], issue};

      if (vld_pipe[1]) sample <= neg_pipe[1] ? -mag : mag;
    end
  end

endmodule
